mig_rw_arbiter: RTL and testbench

MIG_RW_ARBITER -- requirements
Module: mig_rw_arbiter

---
 rtl/mig_rw_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mig_rw_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mig_rw_arbiter.sv
// Arbitrates an AXIS write stream and an AXIS read request/return path onto a
// single MIG UI port, alternating or prioritising writes/reads per mode_in.
//
// Ports:
//   clk_in, rst_n_in          - MIG ui_clk and async active-low reset
//   mode_in                   - 0 alternate, 1 wr prio, 2 rd prio, 3 wr only
//   app_*                     - MIG UI command/write/read/maintenance signals
//   init_calib_complete       - MIG calibration done
//   write_axis_*              - AXIS sink feeding MIG writes (tuser = frame start)
//   read_axis_*               - AXIS source of MIG read returns (tuser = frame start)
//   outstanding_out           - issued-but-unreturned reads
//   rd_overflow_out           - sticky: read beat returned while sink not ready
module mig_rw_arbiter #(
  parameter int DATA_WIDTH      = 128,
  parameter int ADDR_WIDTH      = 27,
  parameter int NUM_BEATS       = 2048,
  parameter int ADDR_SHIFT      = 3,
  parameter int WR_BASE         = 0,
  parameter int RD_BASE         = 0,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic [1:0]                    mode_in,
  output logic [ADDR_WIDTH-1:0]         app_addr,
  output logic [2:0]                    app_cmd,
  output logic                          app_en,
  output logic [DATA_WIDTH-1:0]         app_wdf_data,
  output logic                          app_wdf_end,
  output logic                          app_wdf_wren,
  output logic [DATA_WIDTH/8-1:0]       app_wdf_mask,
  input  logic [DATA_WIDTH-1:0]         app_rd_data,
  input  logic                          app_rd_data_valid,
  input  logic                          app_rdy,
  input  logic                          app_wdf_rdy,
  input  logic                          init_calib_complete,
  output logic                          app_sr_req,
  output logic                          app_ref_req,
  output logic                          app_zq_req,
  input  logic [DATA_WIDTH-1:0]         write_axis_data,
  input  logic                          write_axis_tuser,
  input  logic                          write_axis_valid,
  output logic                          write_axis_ready,
  output logic [DATA_WIDTH-1:0]         read_axis_data,
  output logic                          read_axis_tuser,
  output logic                          read_axis_valid,
  input  logic                          read_axis_ready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_out,
  output logic                          rd_overflow_out
);

  localparam int IW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BEATS - 1);
  localparam logic [OW-1:0] MAX_OUT  = OW'(MAX_OUTSTANDING);

  localparam logic [1:0] S_WAIT_INIT = 2'd0;
  localparam logic [1:0] S_ARB       = 2'd1;
  localparam logic [1:0] S_ISSUE_WR  = 2'd2;
  localparam logic [1:0] S_ISSUE_RD  = 2'd3;

  logic [1:0]    r_state;
  logic          r_last_wr;
  logic [IW-1:0] r_wr_idx;
  logic [IW-1:0] r_rd_idx;
  logic [IW-1:0] r_ret_idx;
  logic [OW-1:0] r_outstanding;
  logic          r_overflow;

  logic          w_wr_req;
  logic          w_rd_req;
  logic          w_any_req;
  logic          w_pick_wr;
  logic          w_in_wr;
  logic          w_in_rd;
  logic          w_wr_fire;
  logic          w_rd_fire;
  logic [IW-1:0] w_wr_idx_eff;
  logic [31:0]   w_wr_lin;
  logic [31:0]   w_rd_lin;

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] v);
    return (v == LAST_IDX) ? '0 : v + IW'(1);
  endfunction

  assign w_wr_req  = write_axis_valid;
  assign w_rd_req  = read_axis_ready
                  && (r_outstanding < MAX_OUT)
                  && (mode_in != 2'd3);
  assign w_any_req = w_wr_req || w_rd_req;

  // Alternate mode: last grant was a read (also the reset value) -> write wins.
  always_comb begin
    w_pick_wr = 1'b0;
    case (mode_in)
      2'd0:    w_pick_wr = w_wr_req && (!w_rd_req || !r_last_wr);
      2'd1:    w_pick_wr = w_wr_req;
      2'd2:    w_pick_wr = w_wr_req && !w_rd_req;
      default: w_pick_wr = w_wr_req;
    endcase
  end

  // Losing calibration blocks any fire in the cycle the FSM is leaving.
  assign w_in_wr = (r_state == S_ISSUE_WR) && init_calib_complete;
  assign w_in_rd = (r_state == S_ISSUE_RD) && init_calib_complete;

  assign write_axis_ready = w_in_wr && app_rdy && app_wdf_rdy;
  assign w_wr_fire        = write_axis_ready && write_axis_valid;
  assign w_rd_fire        = w_in_rd && app_rdy;

  // A frame-start beat lands at index 0 regardless of the running index.
  assign w_wr_idx_eff = write_axis_tuser ? '0 : r_wr_idx;
  assign w_wr_lin     = 32'(WR_BASE) + 32'(w_wr_idx_eff);
  assign w_rd_lin     = 32'(RD_BASE) + 32'(r_rd_idx);

  always_comb begin
    app_addr = '0;
    if (w_wr_fire)
      app_addr = ADDR_WIDTH'(w_wr_lin << ADDR_SHIFT);
    else if (w_rd_fire)
      app_addr = ADDR_WIDTH'(w_rd_lin << ADDR_SHIFT);
  end

  assign app_en       = w_wr_fire || w_rd_fire;
  assign app_cmd      = w_in_rd ? 3'b001 : 3'b000;
  assign app_wdf_wren = w_wr_fire;
  assign app_wdf_end  = w_wr_fire;
  assign app_wdf_data = write_axis_data;
  assign app_wdf_mask = '0;

  assign app_sr_req  = 1'b0;
  assign app_ref_req = 1'b0;
  assign app_zq_req  = 1'b0;

  assign read_axis_valid = app_rd_data_valid;
  assign read_axis_data  = app_rd_data;
  assign read_axis_tuser = app_rd_data_valid && (r_ret_idx == '0);

  assign outstanding_out = r_outstanding;
  assign rd_overflow_out = r_overflow;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state   <= S_WAIT_INIT;
      r_last_wr <= 1'b0;
    end else if (!init_calib_complete) begin
      r_state <= S_WAIT_INIT;
    end else begin
      case (r_state)
        S_WAIT_INIT: r_state <= S_ARB;
        S_ARB: begin
          if (w_any_req) begin
            r_state   <= w_pick_wr ? S_ISSUE_WR : S_ISSUE_RD;
            r_last_wr <= w_pick_wr;
          end
        end
        S_ISSUE_WR: if (w_wr_fire) r_state <= S_ARB;
        S_ISSUE_RD: if (w_rd_fire) r_state <= S_ARB;
        default:    r_state <= S_WAIT_INIT;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr_idx  <= '0;
      r_rd_idx  <= '0;
      r_ret_idx <= '0;
    end else begin
      if (w_wr_fire)         r_wr_idx  <= inc_wrap(w_wr_idx_eff);
      if (w_rd_fire)         r_rd_idx  <= inc_wrap(r_rd_idx);
      if (app_rd_data_valid) r_ret_idx <= inc_wrap(r_ret_idx);
    end
  end

  // A return with nothing outstanding is ignored rather than wrapping.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_outstanding <= '0;
    end else begin
      case ({w_rd_fire, app_rd_data_valid})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   if (r_outstanding != '0)
                   r_outstanding <= r_outstanding - OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      r_overflow <= 1'b0;
    else if (app_rd_data_valid && !read_axis_ready)
      r_overflow <= 1'b1;
  end

endmodule

// File: tb/tb_mig_rw_arbiter.sv
// Scoreboard bench for mig_rw_arbiter: expected MIG commands and read
// returns are queued by the stimulus and checked by negedge monitors.
module tb_mig_rw_arbiter;

  localparam int DW = 128;
  localparam int AW = 27;
  localparam int NB = 4;
  localparam int OW = 4;

  logic          clk;
  logic          rst_n;
  logic [1:0]    mode;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic [DW-1:0] app_wdf_data;
  logic          app_wdf_end;
  logic          app_wdf_wren;
  logic [DW/8-1:0] app_wdf_mask;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          app_rdy;
  logic          app_wdf_rdy;
  logic          calib;
  logic          sr_req, ref_req, zq_req;
  logic [DW-1:0] wdata;
  logic          wuser;
  logic          wvalid;
  logic          wready;
  logic [DW-1:0] rdata;
  logic          ruser;
  logic          rvalid;
  logic          rready;
  logic [OW-1:0] outstanding;
  logic          overflow;

  mig_rw_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BEATS(NB)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .mode_in(mode),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end),
    .app_wdf_wren(app_wdf_wren), .app_wdf_mask(app_wdf_mask),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .init_calib_complete(calib),
    .app_sr_req(sr_req), .app_ref_req(ref_req), .app_zq_req(zq_req),
    .write_axis_data(wdata), .write_axis_tuser(wuser),
    .write_axis_valid(wvalid), .write_axis_ready(wready),
    .read_axis_data(rdata), .read_axis_tuser(ruser),
    .read_axis_valid(rvalid), .read_axis_ready(rready),
    .outstanding_out(outstanding), .rd_overflow_out(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          tuser;
  } beat_t;

  cmd_t  exp_cmd[$];
  beat_t exp_ret[$];
  beat_t wq[$];
  int    n_pass  = 0;
  int    n_total = 0;
  int    tb_ret  = 0;

  task automatic chk(input string name,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h t=%0t", name, act, exp, $time);
  endtask

  // Command and read-return monitor.
  always @(negedge clk) begin
    cmd_t  e;
    beat_t b;
    if (app_en) begin
      chk("cmd_expected", 128'(exp_cmd.size() > 0), 128'(1));
      if (exp_cmd.size() > 0) begin
        e = exp_cmd.pop_front();
        chk("cmd_type", 128'(app_cmd), e.is_wr ? 128'(0) : 128'(1));
        chk("cmd_addr", 128'(app_addr), 128'(e.addr));
        chk("cmd_wren", 128'(app_wdf_wren), 128'(e.is_wr));
        chk("cmd_wend", 128'(app_wdf_end), 128'(e.is_wr));
        if (e.is_wr) chk("cmd_wdata", app_wdf_data, e.data);
      end
    end else begin
      chk("idle_quiet", 128'({app_addr, app_wdf_wren, app_wdf_end}), 128'(0));
    end
    if (rvalid) begin
      chk("ret_expected", 128'(exp_ret.size() > 0), 128'(1));
      if (exp_ret.size() > 0) begin
        b = exp_ret.pop_front();
        chk("ret_data", rdata, b.data);
        chk("ret_tuser", 128'(ruser), 128'(b.tuser));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic present;
    if (wq.size() > 0) begin
      wvalid = 1'b1;
      wdata  = wq[0].data;
      wuser  = wq[0].tuser;
    end else begin
      wvalid = 1'b0;
      wuser  = 1'b0;
    end
  endtask

  task automatic wq_add(input logic [DW-1:0] d, input logic u);
    wq.push_back('{data: d, tuser: u});
    if (!wvalid) present();
  endtask

  // AXIS write source: advance to the next beat after each handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (wvalid && wready) begin
        @(posedge clk);
        #1;
        if (wq.size() > 0) wq.delete(0);
        present();
      end
    end
  end

  task automatic exp_wr(input int idx, input logic [DW-1:0] d);
    exp_cmd.push_back('{is_wr: 1'b1, addr: AW'(idx << 3), data: d});
  endtask

  task automatic exp_rd(input int idx);
    exp_cmd.push_back('{is_wr: 1'b0, addr: AW'(idx << 3), data: '0});
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_cmd.size() != 0; i++)
      @(posedge clk);
    chk("drain_timeout", 128'(exp_cmd.size()), 128'(0));
    exp_cmd.delete();
    #1;
  endtask

  task automatic ret_beat(input logic [DW-1:0] d);
    exp_ret.push_back('{data: d, tuser: (tb_ret == 0)});
    tb_ret = (tb_ret + 1) % NB;
    app_rd_data       = d;
    app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'd0; calib = 1'b0;
    app_rd_data = '0; app_rd_data_valid = 1'b0;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    wdata = '0; wuser = 1'b0; wvalid = 1'b0; rready = 1'b0;

    #1;
    chk("rst_app_en", 128'(app_en), 128'(0));
    chk("rst_wready", 128'(wready), 128'(0));
    chk("rst_outst", 128'(outstanding), 128'(0));
    chk("rst_ovf", 128'(overflow), 128'(0));
    chk("tied_zero", 128'({app_wdf_mask, sr_req, ref_req, zq_req}), 128'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Alternate mode: W,R,W,R,W,R.
    app_rdy = 1'b1; app_wdf_rdy = 1'b1; rready = 1'b1; mode = 2'd0;
    wq_add(128'hD1, 1'b0); wq_add(128'hD2, 1'b0); wq_add(128'hD3, 1'b0);
    exp_wr(0, 128'hD1); exp_rd(0);
    exp_wr(1, 128'hD2); exp_rd(1);
    exp_wr(2, 128'hD3); exp_rd(2);
    tick(); tick();
    chk("no_cmd_precalib", 128'(exp_cmd.size()), 128'(6));
    calib = 1'b1;
    drain(100);
    rready = 1'b0;
    tick();
    chk("alt_outst", 128'(outstanding), 128'(3));
    mode = 2'd3; rready = 1'b1;
    ret_beat(128'hA0); ret_beat(128'hA1); ret_beat(128'hA2);
    chk("alt_outst_ret", 128'(outstanding), 128'(0));

    // Read priority: 8 reads cap outstanding, then writes.
    mode = 2'd2;
    for (int i = 0; i < 8; i++) exp_rd((3 + i) % NB);
    exp_wr(3, 128'hE1); exp_wr(0, 128'hE2);
    wq_add(128'hE1, 1'b0); wq_add(128'hE2, 1'b0);
    drain(200);
    chk("cap_outst", 128'(outstanding), 128'(8));
    exp_rd(3);
    ret_beat(128'hB0);
    drain(20);
    chk("cap_refill", 128'(outstanding), 128'(8));
    mode = 2'd3;
    for (int i = 0; i < 8; i++) ret_beat(128'hC0 + 128'(i));
    chk("cap_drained", 128'(outstanding), 128'(0));

    // Write-only: wrap and tuser index reset.
    wq_add(128'hF0, 1'b1); exp_wr(0, 128'hF0);
    wq_add(128'hF1, 1'b0); exp_wr(1, 128'hF1);
    wq_add(128'hF2, 1'b0); exp_wr(2, 128'hF2);
    wq_add(128'hF3, 1'b0); exp_wr(3, 128'hF3);
    wq_add(128'hF4, 1'b0); exp_wr(0, 128'hF4);
    wq_add(128'hF5, 1'b0); exp_wr(1, 128'hF5);
    wq_add(128'hF6, 1'b1); exp_wr(0, 128'hF6);
    wq_add(128'hF7, 1'b0); exp_wr(1, 128'hF7);
    drain(100);

    // Read stalled by app_rdy for 5 cycles, then a single fire.
    app_rdy = 1'b0; mode = 2'd2; rready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_en", 128'(app_en), 128'(0));
      chk("stall_cmd", 128'(app_cmd), 128'(1));
    end
    exp_rd(0);
    @(posedge clk);
    #1;
    app_rdy = 1'b1;
    drain(20);
    rready = 1'b0;
    tick(); tick();
    chk("stall_outst", 128'(outstanding), 128'(1));

    // Return with sink not ready sets the sticky overflow.
    mode = 2'd3;
    ret_beat(128'h51);
    chk("ovf_set", 128'(overflow), 128'(1));
    chk("ovf_outst", 128'(outstanding), 128'(0));
    tick(); tick(); tick();
    rready = 1'b1;
    tick();
    chk("ovf_sticky", 128'(overflow), 128'(1));
    for (int i = 0; i < 4; i++) ret_beat(128'h52 + 128'(i));

    // Async reset mid-write drops the command until calibration.
    app_wdf_rdy = 1'b0;
    wq_add(128'h60, 1'b0);
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", 128'(app_en), 128'(0));
    chk("mid_rst_ovf", 128'(overflow), 128'(0));
    chk("mid_rst_wready", 128'(wready), 128'(0));
    calib = 1'b0; app_wdf_rdy = 1'b1;
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("nocalib_wready", 128'(wready), 128'(0));
    exp_wr(0, 128'h60);
    calib = 1'b1;
    drain(20);

    // Calibration loss from ISSUE_WR keeps indices.
    app_wdf_rdy = 1'b0;
    wq_add(128'h61, 1'b0);
    tick(); tick();
    calib = 1'b0;
    tick();
    app_wdf_rdy = 1'b1;
    tick();
    chk("calib_lost_wready", 128'(wready), 128'(0));
    exp_wr(1, 128'h61);
    calib = 1'b1;
    drain(20);
    tick();
    chk("ret_queue_empty", 128'(exp_ret.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
